sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
Upstream message-schedule stage for the SHA-256 compression round datapath. It accepts one padded 512-bit block as 16 big-endian 32-bit words through a valid/ready handshake. It then streams W[t] and K[t] with a round index t, one round per cycle, on the w/k/count/padding_done interface that the compression rounds consume. It keeps a 16-word circular buffer and holds the K constants in an internal ROM.

Parameters:
NUM_ROUNDS, 64, number of rounds streamed; fixed at 64 for SHA-256, and the count encoding depends on it
CNT_W, 7, width of o_count; must hold NUM_ROUNDS+1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-low reset
i_word_valid  in  1  message word valid
i_word  in  32  message word; W[0] first
o_word_ready  out  1  block accepts a word; equals (state==IDLE)
i_next  in  1  in DONE, release the schedule and return to IDLE for the next block
o_w  out  32  W[t] for round t=o_count
o_k  out  32  K[t] for round t=o_count
o_count  out  7  round index 0..63, then 64, then 65 (hold)
o_padding_done  out  1  block loaded; schedule valid from this cycle
o_done  out  1  all 64 rounds emitted

Behaviour:
- Reset is applied when i_rst=0 at a clock edge, and it overrides everything. Reset values:
  - state=IDLE, load_cnt=0, o_count=0
  - o_w=0, o_k=0, o_padding_done=0, o_done=0
  - o_word_ready=1
  - Buffer contents are don't-care.
- Reset during LOAD or RUN discards the partial block; no output glitches beyond the reset values.
- FSM states: IDLE, PRIME, RUN, DONE.
- IDLE:
  - A word is taken when i_word_valid & o_word_ready; it is written to buf[load_cnt] and load_cnt increments.
  - When the 16th word is taken, load_cnt returns to 0 and the next state is PRIME.
  - With i_word_valid=0, nothing changes; gaps between words are allowed.
- PRIME (1 cycle): o_padding_done=1, o_count=0, o_w=buf[0], o_k=K[0]; next state is RUN.
- RUN:
  - The t=0 outputs are held for this first RUN cycle, so t=0 is presented for 2 cycles.
  - After that, o_count increments by 1 every cycle, with o_w=W[t] and o_k=K[t], all registered.
  - For t<16: W[t]=buf[t].
  - For t>=16: W[t]=σ1(buf[(t-2)&15]) + buf[(t-7)&15] + σ0(buf[(t-15)&15]) + buf[t&15], mod 2^32. The result is written back to buf[t&15] in the same cycle it is emitted.
  - σ0(x)=ROTR7^ROTR18^SHR3. σ1(x)=ROTR17^ROTR19^SHR10.
- After t=63: o_count=64 for one cycle, with o_w/o_k holding their t=63 values. Then o_count=65 and the state becomes DONE, with o_done=1.
- DONE:
  - o_count stays at 65; o_w, o_k and o_padding_done hold.
  - i_next=1 moves to IDLE with o_padding_done=0, o_done=0, o_count=0.
  - i_next outside DONE is ignored.
- i_word_valid outside IDLE is ignored; o_word_ready=0 there.
- The block has no backpressure in the base build. The consumer must accept one round per cycle.

Optional Feature:
SCHED_STALL_EN:
- Defined: adds input i_stall (1 bit). While i_stall=1 in PRIME or RUN, the state, o_count, o_w, o_k and the buffer all hold; rounds do not advance or write back. i_stall has no effect in IDLE or DONE, and reset overrides it.
- Undefined: the port is absent and the schedule advances unconditionally.

Test Plan:
- Reset: drive i_rst=0 for 2 cycles. Expect all outputs 0 except o_word_ready=1.
- "abc" block: load 0x61626380, fourteen 0x00000000 words, then 0x00000018. Expect:
  - o_padding_done rises on the cycle after the 16th word, with o_count=0, o_w=0x61626380, o_k=0x428a2f98.
  - t=0 is held for 2 cycles.
  - t=16 gives o_w=0x61626380; t=17 gives 0x000f0000; t=18 gives 0x7da86405.
- Same run, end of schedule: t=63 gives o_k=0xc67178f2. Then o_count=64 for one cycle, then 65 held with o_done=1. Pulse i_next and expect IDLE with o_word_ready=1.
- Gapped load: deassert i_word_valid for 3 cycles between words 5 and 6. Expect W[16..18] identical to the "abc" case.
- Reset mid-RUN at t=30 with i_rst=0 for 1 cycle. Expect the reset values, then a fresh "abc" load reproduces the same W stream.
- With SCHED_STALL_EN: assert i_stall for 4 cycles at t=20. Expect o_count=20 and o_w constant, and the W stream after release identical to the unstalled run.

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_schedule_if
//   Bundles the word-load handshake and the round-stream outputs of the
//   SHA-256 message-schedule stage.
//
//   Optional feature macro: SCHED_STALL_EN (adds i_stall).
//
//   Signals:
//     i_word_valid   message word valid
//     i_word[31:0]   message word, W[0] first
//     o_word_ready   stage accepts a word (idle)
//     i_next         release a finished schedule
//     o_w[31:0]      W[t] for t = o_count
//     o_k[31:0]      K[t] for t = o_count
//     o_count        round index 0..63, then 64, then 65 (held)
//     o_padding_done block loaded, schedule valid
//     o_done         all rounds emitted
//     i_stall        (SCHED_STALL_EN only) freeze the round stream
//
//   Modports:
//     slave  - the schedule stage itself
//     master - the word source / round consumer
// ---------------------------------------------------------------------------
interface sha256_msg_schedule_if #(
    parameter int CNT_W = 7
);
    logic             i_word_valid;
    logic [31:0]      i_word;
    logic             o_word_ready;
    logic             i_next;
    logic [31:0]      o_w;
    logic [31:0]      o_k;
    logic [CNT_W-1:0] o_count;
    logic             o_padding_done;
    logic             o_done;
`ifdef SCHED_STALL_EN
    logic             i_stall;
`endif

    modport slave (
`ifdef SCHED_STALL_EN
        input  i_stall,
`endif
        input  i_word_valid, i_word, i_next,
        output o_word_ready, o_w, o_k, o_count, o_padding_done, o_done
    );

    modport master (
`ifdef SCHED_STALL_EN
        output i_stall,
`endif
        output i_word_valid, i_word, i_next,
        input  o_word_ready, o_w, o_k, o_count, o_padding_done, o_done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// sha256_msg_schedule
//   SHA-256 message schedule. Loads one padded 512-bit block as 16 words,
//   then streams W[t]/K[t] with round index t, one round per cycle, to the
//   compression rounds. W[16..63] are produced in place in a 16-word
//   circular buffer; K[t] comes from an internal constant ROM.
//
//   Optional feature macro: SCHED_STALL_EN
//     defined   : bus.i_stall freezes PRIME/RUN (state, count, outputs, buffer)
//     undefined : no stall input, the schedule advances every cycle
//
//   Ports:
//     i_clk  clock
//     i_rst  synchronous reset, active low
//     bus    sha256_msg_schedule_if.slave (load handshake + round stream)
// ---------------------------------------------------------------------------
module sha256_msg_schedule #(
    parameter int NUM_ROUNDS = 64,
    parameter int CNT_W      = 7
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    sha256_msg_schedule_if.slave     bus
);
    localparam int T_W = $clog2(NUM_ROUNDS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(NUM_ROUNDS + 1);

    localparam logic [31:0] K_ROM [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_load_cnt;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_w;
    logic [31:0]      r_k;
    logic             r_padding_done;
    logic             r_done;
    logic [31:0]      r_buf [0:15];

    logic             w_take;
    logic             w_advance;
    logic             w_emit;
    logic [T_W-1:0]   w_t;
    logic [3:0]       w_idx_t;
    logic [3:0]       w_idx_m2;
    logic [3:0]       w_idx_m7;
    logic [3:0]       w_idx_m15;
    logic [31:0]      w_sched;
    logic [31:0]      w_w_next;
    logic             w_buf_we;
    logic [3:0]       w_buf_idx;
    logic [31:0]      w_buf_wdata;

    assign w_take = bus.i_word_valid && (r_state == S_IDLE);

`ifdef SCHED_STALL_EN
    assign w_advance = !bus.i_stall;
`else
    assign w_advance = 1'b1;
`endif

    // w_t is the round that the next RUN advance will present.
    assign w_t       = r_count[T_W-1:0] + T_W'(1);
    assign w_emit    = (r_state == S_RUN) && w_advance && (r_count < CNT_LAST);

    // Circular-buffer taps: buf[t&15] still holds W[t-16] until overwritten.
    assign w_idx_t   = w_t[3:0];
    assign w_idx_m2  = w_t[3:0] - 4'd2;
    assign w_idx_m7  = w_t[3:0] - 4'd7;
    assign w_idx_m15 = w_t[3:0] + 4'd1;

    assign w_sched = f_sigma1(r_buf[w_idx_m2]) + r_buf[w_idx_m7]
                   + f_sigma0(r_buf[w_idx_m15]) + r_buf[w_idx_t];

    assign w_w_next = (w_t < T_W'(16)) ? r_buf[w_idx_t] : w_sched;

    always_comb begin
        w_buf_we    = 1'b0;
        w_buf_idx   = r_load_cnt;
        w_buf_wdata = bus.i_word;
        if (w_take) begin
            w_buf_we = 1'b1;
        end else if (w_emit && (w_t >= T_W'(16))) begin
            w_buf_we    = 1'b1;
            w_buf_idx   = w_idx_t;
            w_buf_wdata = w_sched;
        end
    end

    // Buffer contents survive reset; only the write is suppressed.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_buf_we) begin
            r_buf[w_buf_idx] <= w_buf_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take && (r_load_cnt == 4'd15)) begin
                    w_state_next = S_PRIME;
                end
            end
            S_PRIME: begin
                if (w_advance) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_advance && (r_count == CNT_END)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.i_next) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_load_cnt     <= '0;
            r_count        <= '0;
            r_w            <= '0;
            r_k            <= '0;
            r_padding_done <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_load_cnt <= r_load_cnt + 4'd1;
                        // Last word: word 0 is already in the buffer, so
                        // round 0 can be presented during PRIME.
                        if (r_load_cnt == 4'd15) begin
                            r_count        <= '0;
                            r_w            <= r_buf[0];
                            r_k            <= K_ROM[0];
                            r_padding_done <= 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    // Round 0 stays on the outputs through the first RUN cycle.
                end
                S_RUN: begin
                    if (w_advance) begin
                        if (r_count < CNT_LAST) begin
                            r_count <= CNT_W'(w_t);
                            r_w     <= w_w_next;
                            r_k     <= K_ROM[w_t];
                        end else if (r_count == CNT_LAST) begin
                            r_count <= CNT_END;
                        end else begin
                            r_count <= CNT_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.i_next) begin
                        r_count        <= '0;
                        r_padding_done <= 1'b0;
                        r_done         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_word_ready   = (r_state == S_IDLE);
    assign bus.o_w            = r_w;
    assign bus.o_k            = r_k;
    assign bus.o_count        = r_count;
    assign bus.o_padding_done = r_padding_done;
    assign bus.o_done         = r_done;
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_schedule
//   Self-checking bench for sha256_msg_schedule. A textbook SHA-256 W[]
//   expansion and K constants (from cube roots of the first 64 primes)
//   produce the expected round stream; a monitor compares every distinct
//   presentation of o_count against that stream, including how many cycles
//   each round stays on the outputs.
// ---------------------------------------------------------------------------
module tb_sha256_msg_schedule;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sha256_msg_schedule_if ifc();

    sha256_msg_schedule dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc)
    );

    typedef logic [31:0] blk_t [16];
    typedef struct {
        logic [6:0]  cnt;
        logic [31:0] w;
        logic [31:0] k;
        logic        done;
        int          hold;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [31:0] k_ref [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // K[i] = first 32 fractional bits of the cube root of the i-th prime.
    task automatic init_k();
        int  n;
        int  p;
        bit  is_prime;
        real c;
        real f;
        n = 0;
        p = 2;
        while (n < 64) begin
            is_prime = 1'b1;
            for (int d = 2; d * d <= p; d++) begin
                if (p % d == 0) is_prime = 1'b0;
            end
            if (is_prime) begin
                c = $pow(real'(p), 1.0 / 3.0);
                c = c - (c * c * c - real'(p)) / (3.0 * c * c);
                f = $floor((c - $floor(c)) * 4294967296.0);
                k_ref[n] = 32'(longint'(f));
                n++;
            end
            p++;
        end
    endtask

    // Expected stream for one block; stall_t/stall_len lengthen one round.
    task automatic push_block(input blk_t blk, input int stall_t, input int stall_len);
        logic [31:0] w [64];
        exp_t        e;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            e.cnt  = 7'(t);
            e.w    = w[t];
            e.k    = k_ref[t];
            e.done = 1'b0;
            e.hold = ((t == 0) ? 2 : 1) + ((t == stall_t) ? stall_len : 0);
            sb.push_back(e);
        end
        e.cnt = 7'd64; e.w = w[63]; e.k = k_ref[63]; e.done = 1'b0; e.hold = 1;
        sb.push_back(e);
        e.cnt = 7'd65; e.done = 1'b1; e.hold = 0;
        sb.push_back(e);
    endtask

    task automatic drive_block(input blk_t blk, input int gap_after, input int gap_len);
        for (int i = 0; i < 16; i++) begin
            ifc.i_word_valid = 1'b1;
            ifc.i_word       = blk[i];
            @(posedge clk); #1;
            if (i == gap_after && gap_len > 0) begin
                ifc.i_word_valid = 1'b0;
                ifc.i_word       = $urandom;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        ifc.i_word_valid = 1'b0;
        @(negedge clk);
        check("pd_rise", 32'(ifc.o_padding_done), 32'd1);
        check("ready_low", 32'(ifc.o_word_ready), 32'd0);
    endtask

    task automatic wait_count(input logic [6:0] target);
        int n;
        n = 0;
        while (ifc.o_count !== target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_count: count=%0d never reached %0d", ifc.o_count, target);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_w"}, ifc.o_w, 32'd0);
        check({tag, "_k"}, ifc.o_k, 32'd0);
        check({tag, "_count"}, 32'(ifc.o_count), 32'd0);
        check({tag, "_pd"}, 32'(ifc.o_padding_done), 32'd0);
        check({tag, "_done"}, 32'(ifc.o_done), 32'd0);
        check({tag, "_ready"}, 32'(ifc.o_word_ready), 32'd1);
    endtask

    task automatic finish_block(input int next_delay);
        int n;
        n = 0;
        while (ifc.o_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_done: o_done=%b count=%0d", ifc.o_done, ifc.o_count);
        end
        repeat (next_delay) @(negedge clk);
        check("done_hold_count", 32'(ifc.o_count), 32'd65);
        check("done_hold_done", 32'(ifc.o_done), 32'd1);
        ifc.i_word_valid = 1'b0;
        @(posedge clk); #1;
        ifc.i_next = 1'b1;
        @(posedge clk); #1;
        ifc.i_next = 1'b0;
        @(negedge clk);
        check("next_ready", 32'(ifc.o_word_ready), 32'd1);
        check("next_count", 32'(ifc.o_count), 32'd0);
        check("next_pd", 32'(ifc.o_padding_done), 32'd0);
        check("next_done", 32'(ifc.o_done), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("block finished: checks=%0d failures=%0d", total, bad);
    endtask

    // Monitor: one pop per new o_count value while the schedule is valid.
    initial begin
        logic        mon_active;
        logic [6:0]  mon_cnt;
        logic [31:0] mon_w;
        logic [31:0] mon_k;
        int          mon_hold;
        int          mon_exp_hold;
        exp_t        e;
        mon_active   = 1'b0;
        mon_cnt      = '0;
        mon_w        = '0;
        mon_k        = '0;
        mon_hold     = 0;
        mon_exp_hold = 0;
        forever begin
            @(negedge clk);
            if (rst && ifc.o_padding_done) begin
                if (!mon_active || ifc.o_count != mon_cnt) begin
                    if (mon_active) check("hold_len", 32'(mon_hold), 32'(mon_exp_hold));
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty: unexpected count=%0d w=%h", ifc.o_count, ifc.o_w);
                    end else begin
                        e = sb.pop_front();
                        check("count", 32'(ifc.o_count), 32'(e.cnt));
                        check("w", ifc.o_w, e.w);
                        check("k", ifc.o_k, e.k);
                        check("done", 32'(ifc.o_done), 32'(e.done));
                        mon_exp_hold = e.hold;
                    end
                    mon_active = 1'b1;
                    mon_cnt    = ifc.o_count;
                    mon_w      = ifc.o_w;
                    mon_k      = ifc.o_k;
                    mon_hold   = 1;
                end else begin
                    mon_hold++;
                    check("hold_w", ifc.o_w, mon_w);
                    check("hold_k", ifc.o_k, mon_k);
                end
            end else begin
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        blk_t abc;
        blk_t rnd;
        int   gap_at;
        int   gap_len;
        init_k();
        ifc.i_word_valid = 1'b0;
        ifc.i_word       = '0;
        ifc.i_next       = 1'b0;
`ifdef SCHED_STALL_EN
        ifc.i_stall      = 1'b0;
`endif
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b1;

        // "abc" block with known values
        push_block(abc, -1, 0);
        drive_block(abc, -1, 0);
        check("abc_t0_w", ifc.o_w, 32'h61626380);
        check("abc_t0_k", ifc.o_k, 32'h428a2f98);
        wait_count(7'd16);
        check("abc_w16", ifc.o_w, 32'h61626380);
        wait_count(7'd17);
        check("abc_w17", ifc.o_w, 32'h000f0000);
        wait_count(7'd18);
        check("abc_w18", ifc.o_w, 32'h7da86405);
        wait_count(7'd63);
        check("abc_k63", ifc.o_k, 32'hc67178f2);
        finish_block(2);

        // Gapped load between words 5 and 6
        push_block(abc, -1, 0);
        drive_block(abc, 5, 3);
        finish_block(0);

        // Reset in the middle of RUN
        push_block(abc, -1, 0);
        drive_block(abc, -1, 0);
        wait_count(7'd30);
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        push_block(abc, -1, 0);
        drive_block(abc, -1, 0);
        finish_block(1);

`ifdef SCHED_STALL_EN
        // Stall four cycles at round 20
        push_block(abc, 20, 4);
        drive_block(abc, -1, 0);
        wait_count(7'd20);
        ifc.i_stall = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ifc.i_stall = 1'b0;
        finish_block(0);
`endif

        // Random blocks; stray i_word_valid and i_next during RUN are ignored
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            gap_at  = $urandom_range(0, 14);
            gap_len = $urandom_range(0, 4);
            push_block(rnd, -1, 0);
            drive_block(rnd, gap_at, gap_len);
            ifc.i_word_valid = 1'b1;
            ifc.i_word       = $urandom;
            wait_count(7'(10 + b * 7));
            ifc.i_next = 1'b1;
            @(posedge clk); #1;
            ifc.i_next = 1'b0;
            finish_block($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
